// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the single byte-addressable data memory port.
// Each grant runs IDLE -> ACCESS -> RESP; illegal accesses are answered with err and never reach memory.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   input  logic [1:0]            m0_size,
   output logic                  m0_ack,
   output logic                  m0_err,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   input  logic [1:0]            m1_size,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wd,
   output logic [1:0]            mem_size,
   input  logic [DATA_WIDTH-1:0] mem_rd,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);

   // End address is formed one bit wider than the bus so a high address cannot wrap past the check.
   function automatic logic access_err(input logic [ADDR_WIDTH-1:0] addr, input logic [1:0] size);
      logic [ADDR_WIDTH:0] end_addr;
      logic                misaligned;
      end_addr   = {1'b0, addr} + ((ADDR_WIDTH+1)'(1) << size);
      misaligned = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
      return (size == 2'b11) || misaligned || (end_addr > DEPTH_EXT);
   endfunction

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  win_q, win_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            size_q, size_d;
   logic                  err_q, err_d;
   logic                  m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
   logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic                  pick;
   logic [DATA_WIDTH-1:0] rd_val;

   always_comb begin
      // NOTE: every _d starts from its _q (or 0 for pulses) so no path through this block can infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      win_d        = win_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      err_d        = err_q;
      m0_ack_d     = 1'b0;
      m1_ack_d     = 1'b0;
      m0_err_d     = 1'b0;
      m1_err_d     = 1'b0;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      pick         = 1'b0;
      rd_val       = '0;

      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               if (m0_req && m1_req) begin
                  pick         = ~last_grant_q;
                  last_grant_d = pick;
               end else begin
                  pick = m1_req;
               end
               win_d   = pick;
               we_d    = pick ? m1_we    : m0_we;
               addr_d  = pick ? m1_addr  : m0_addr;
               wdata_d = pick ? m1_wdata : m0_wdata;
               size_d  = pick ? m1_size  : m0_size;
               err_d   = access_err(addr_d, size_d);
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (!we_q && !err_q) rd_val = mem_rd;
            if (win_q) begin
               m1_rdata_d = rd_val;
               m1_ack_d   = 1'b1;
               m1_err_d   = err_q;
            end else begin
               m0_rdata_d = rd_val;
               m0_ack_d   = 1'b1;
               m0_err_d   = err_q;
            end
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         win_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         err_q        <= 1'b0;
         m0_ack_q     <= 1'b0;
         m1_ack_q     <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         // NOTE: non-blocking so every flop updates from pre-edge values regardless of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         win_q        <= win_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         err_q        <= err_d;
         m0_ack_q     <= m0_ack_d;
         m1_ack_q     <= m1_ack_d;
         m0_err_q     <= m0_err_d;
         m1_err_q     <= m1_err_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   // Write enable is decoded from state so an asynchronous reset kills it immediately.
   assign mem_we   = (state_q == ACCESS) && we_q && !err_q;
   assign mem_addr = addr_q;
   assign mem_wd   = wdata_q;
   assign mem_size = size_q;
   assign busy     = (state_q != IDLE);

   assign m0_ack   = m0_ack_q;
   assign m1_ack   = m1_ack_q;
   assign m0_err   = m0_err_q;
   assign m1_err   = m1_err_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte memory device, transaction-level reference model checked every
// cycle, and directed accesses with hand-computed literal results.
module tb_mem_port_arbiter;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic [1:0]  m0_size = '0, m1_size = '0;
   logic        m0_ack, m1_ack, m0_err, m1_err, mem_we, busy;
   logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wd, mem_rd;
   logic [1:0]  mem_size;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_size(mem_size),
      .mem_rd(mem_rd), .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- memory device (initial contents byte[i] = i*7+3) ----------------
   logic [7:0] dev_mem [DEPTH];
   bit         dev_loaded = 1'b0;

   always_comb begin
      mem_rd = '0;
      for (int i = 0; i < 4; i++) begin
         if ({32'b0, mem_addr} + 64'(i) < 64'(DEPTH))
            mem_rd[8*i +: 8] = dev_mem[mem_addr[9:0] + 10'(i)];
      end
   end

   always @(posedge clk) begin
      if (!dev_loaded) begin
         for (int i = 0; i < DEPTH; i++) dev_mem[i] <= 8'(i * 7 + 3);
         dev_loaded <= 1'b1;
      end else if (mem_we && mem_size != 2'b11) begin
         for (int i = 0; i < 4; i++) begin
            if (i < (1 << mem_size) && {32'b0, mem_addr} + 64'(i) < 64'(DEPTH))
               dev_mem[mem_addr[9:0] + 10'(i)] <= mem_wd[8*i +: 8];
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]  model_mem [DEPTH];
   bit          model_loaded = 1'b0;
   int          cnt = 0;           // cycles left in the current access: 2 = memory cycle, 1 = response cycle
   bit          c_win = 1'b0, c_we = 1'b0, c_err = 1'b0, last_grant = 1'b1, w;
   logic [31:0] c_addr = '0, c_wd = '0;
   logic [1:0]  c_size = '0;
   logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
   int          cyc = 0;
   int          ack_log[$];
   int          ack_cyc[$];
   int          ack_cnt [2] = '{0, 0};

   function automatic bit spec_err(input logic [31:0] a, input logic [1:0] s);
      longint unsigned aa = 64'(a);
      longint unsigned n  = 64'd1 << s;
      return (s == 2'b11) || (aa % n != 0) || (aa + n > 64'(DEPTH));
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++)
         if (64'(a) + 64'(i) < 64'(DEPTH)) r[8*i +: 8] = model_mem[a[9:0] + 10'(i)];
      return r;
   endfunction

   always @(negedge clk) begin
      if (!model_loaded) begin
         for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'(i * 7 + 3);
         model_loaded = 1'b1;
      end
      if (reset) begin
         check("rst_busy", busy, 0);
         check("rst_mem_we", mem_we, 0);
         check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
         check("rst_rdata", {m0_rdata, m1_rdata}, 0);
         check("rst_mem_cmd", {mem_addr, mem_wd[29:0], mem_size}, 0);
         cnt = 0; last_grant = 1'b1; c_addr = '0; c_wd = '0; c_size = '0;
         c_we = 1'b0; c_err = 1'b0; c_win = 1'b0;
         exp_rdata[0] = '0; exp_rdata[1] = '0;
      end else begin
         check("busy", busy, cnt != 0);
         check("mem_we", mem_we, cnt == 2 && c_we && !c_err);
         check("mem_addr", mem_addr, c_addr);
         check("mem_wd", mem_wd, c_wd);
         check("mem_size", mem_size, c_size);
         check("m0_ack", m0_ack, cnt == 1 && !c_win);
         check("m1_ack", m1_ack, cnt == 1 && c_win);
         check("m0_err", m0_err, cnt == 1 && !c_win && c_err);
         check("m1_err", m1_err, cnt == 1 && c_win && c_err);
         check("m0_rdata", m0_rdata, exp_rdata[0]);
         check("m1_rdata", m1_rdata, exp_rdata[1]);
         if (m0_ack) begin ack_log.push_back(0); ack_cyc.push_back(cyc); ack_cnt[0]++; end
         if (m1_ack) begin ack_log.push_back(1); ack_cyc.push_back(cyc); ack_cnt[1]++; end
         // advance to what the next cycle must show
         if (cnt == 2) begin
            if (c_we && !c_err)
               for (int i = 0; i < (1 << c_size); i++) model_mem[c_addr[9:0] + 10'(i)] = c_wd[8*i +: 8];
            exp_rdata[c_win] = (!c_we && !c_err) ? model_read(c_addr) : 32'h0;
            cnt = 1;
         end else if (cnt == 1) begin
            cnt = 0;
         end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) begin w = !last_grant; last_grant = w; end
            else w = m1_req;
            c_win  = w;
            c_we   = w ? m1_we : m0_we;
            c_addr = w ? m1_addr : m0_addr;
            c_wd   = w ? m1_wdata : m0_wdata;
            c_size = w ? m1_size : m0_size;
            c_err  = spec_err(c_addr, c_size);
            cnt    = 2;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic access(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input int n,
                         output logic [31:0] rdata, output logic err, output int lat);
      int got = 0;
      lat = -1; rdata = '0; err = 1'b0;
      @(posedge clk); #1;
      if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_size = size; end
      else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_size = size; end
      for (int c = 0; c < 20 * n && got < n; c++) begin
         @(negedge clk);
         if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
            got++;
            if (lat < 0) lat = c;
            rdata = (m == 0) ? m0_rdata : m1_rdata;
            err   = (m == 0) ? m0_err : m1_err;
         end
      end
      check("ack_seen", got, n);
      @(posedge clk); #1;
      if (m == 0) m0_req = 0; else m1_req = 0;
   endtask

   task automatic watch(output logic [3:0] b, output logic [3:0] wv);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b[i]  = busy;
         wv[i] = mem_we;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, rd1;
      logic        er, er1;
      int          lat, lat1, a0;
      logic [3:0]  b, wv;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("post_rst_busy", busy, 0);
      check("post_rst_rdata", m0_rdata, 0);

      // word write then read-back, with handshake timing
      fork
         access(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 1, rd, er, lat);
         watch(b, wv);
      join
      check("wr_err", er, 0);
      check("wr_lat", lat, 2);
      check("wr_busy_pat", b, 4'b0110);
      check("wr_we_pat", wv, 4'b0010);
      fork
         access(0, 0, 32'h10, 32'h0, 2'b10, 1, rd, er, lat);
         watch(b, wv);
      join
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_err", er, 0);
      check("rd_lat", lat, 2);
      check("rd_busy_pat", b, 4'b0110);
      check("rd_we_pat", wv, 4'b0000);

      // last legal word
      access(0, 1, 32'h3FC, 32'hCAFEF00D, 2'b10, 1, rd, er, lat);
      check("top_wr_err", er, 0);
      access(0, 0, 32'h3FC, 32'h0, 2'b10, 1, rd, er, lat);
      check("top_rd_err", er, 0);
      check("top_rd_data", rd, 32'hCAFEF00D);

      // byte merge from m1
      access(1, 1, 32'h10, 32'h11223344, 2'b10, 1, rd, er, lat);
      access(1, 1, 32'h13, 32'h000000AA, 2'b00, 1, rd, er, lat);
      check("byte_wr_err", er, 0);
      access(1, 0, 32'h10, 32'h0, 2'b10, 1, rd, er, lat);
      check("byte_merge", rd, 32'hAA223344);

      // illegal accesses
      fork
         access(0, 1, 32'h02, 32'h55555555, 2'b10, 1, rd, er, lat);
         watch(b, wv);
      join
      check("misalign_err", er, 1);
      check("misalign_no_we", wv, 4'b0000);
      check("misalign_mem2", dev_mem[2], 8'h11);
      check("misalign_mem5", dev_mem[5], 8'h26);
      access(1, 0, 32'h10, 32'h0, 2'b11, 1, rd, er, lat);
      check("size11_err", er, 1);
      check("size11_rdata", rd, 0);
      access(0, 0, 32'h3FE, 32'h0, 2'b10, 1, rd, er, lat);
      check("oversize_err", er, 1);
      access(0, 0, 32'h3FF, 32'h0, 2'b00, 1, rd, er, lat);
      check("last_byte_err", er, 0);
      check("last_byte_data", rd, 32'h000000CA);
      access(1, 0, 32'hFFFFFFFF, 32'h0, 2'b01, 1, rd, er, lat);
      check("wrap_err", er, 1);
      check("wrap_rdata", rd, 0);

      // both requesting continuously
      ack_log.delete(); ack_cyc.delete();
      fork
         access(0, 0, 32'h10, 32'h0, 2'b10, 2, rd, er, lat);
         access(1, 0, 32'h3FC, 32'h0, 2'b10, 2, rd1, er1, lat1);
      join
      check("rr_count", ack_log.size(), 4);
      if (ack_log.size() == 4) begin
         check("rr_order", {ack_log[0][3:0], ack_log[1][3:0], ack_log[2][3:0], ack_log[3][3:0]}, 16'h0101);
         check("rr_gap1", ack_cyc[1] - ack_cyc[0], 3);
         check("rr_gap2", ack_cyc[2] - ack_cyc[1], 3);
         check("rr_gap3", ack_cyc[3] - ack_cyc[2], 3);
      end
      check("rr_m0_data", rd, 32'hAA223344);
      check("rr_m1_data", rd1, 32'hCAFEF00D);

      // reset in the memory cycle of a write
      @(posedge clk); #1;
      m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'h12345678; m0_size = 2'b10;
      a0 = ack_cnt[0];
      @(posedge clk); #1;
      check("abort_we_before", mem_we, 1);
      #1 reset = 1'b1;
      #1;
      check("abort_we_drop", mem_we, 0);
      check("abort_busy", busy, 0);
      m0_req = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_ack", ack_cnt[0], a0);
      check("abort_mem", {dev_mem[8'h23], dev_mem[8'h22], dev_mem[8'h21], dev_mem[8'h20]}, 32'hF8F1EAE3);

      ack_log.delete(); ack_cyc.delete();
      fork
         access(0, 0, 32'h20, 32'h0, 2'b10, 1, rd, er, lat);
         access(1, 0, 32'h20, 32'h0, 2'b10, 1, rd1, er1, lat1);
      join
      check("post_abort_first", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
      check("post_abort_m0", rd, 32'hF8F1EAE3);
      check("post_abort_m1", rd1, 32'hF8F1EAE3);

      begin
         int mism = 0;
         for (int i = 0; i < DEPTH; i++) if (dev_mem[i] !== model_mem[i]) mism++;
         check("mem_final", mism, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable data memory port between two requesters: m0 (CPU load/store unit) and m1 (UART loader/debug path).
- Uses round-robin arbitration and a req/ack handshake, and performs one access per grant.
- Registers the winner's command, drives the memory write-enable, address, write-data and size pins, and captures the combinational read data.
- Rejects misaligned, oversize or out-of-range accesses without touching memory.

Parameters:
- ADDR_WIDTH, 32, address bus width on both requesters and the memory side.
- DATA_WIDTH, 32, data width; fixed at 4 bytes (BYTE_SIZE*8).
- DEPTH, 1024, memory size in bytes; used for the range check.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  access request; must stay high with stable command until ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_WIDTH  byte address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data, little-endian, byte 0 = bits 7:0
- m0_size, m1_size  in  2  00 = 1B, 01 = 2B, 10 = 4B, 11 = illegal
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  valid with ack; 1 = access rejected
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data, valid with ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wd  out  DATA_WIDTH  memory write data
- mem_size  out  2  memory Size_Write
- mem_rd  in  DATA_WIDTH  memory combinational read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset is asynchronous.
  - Reset values: state = IDLE; all ack, err and rdata = 0; mem_we = 0; mem_addr, mem_wd, mem_size = 0; last_grant = 1, so m0 wins the first tie.
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Each access takes 3 cycles.
- IDLE: sample requests at the clock edge.
  - Only one req high: grant that requester.
  - Both high: grant the requester opposite last_grant, then update last_grant.
  - Neither high: stay in IDLE.
  - On grant: register the command (we, addr, wdata, size), the err_q check result and the winner id. Next state = ACCESS.
- err_q = 1 in any of these cases:
  - size == 11
  - addr not aligned to the size (2B needs addr[0] = 0; 4B needs addr[1:0] = 0)
  - addr + (1 << size) > DEPTH, computed in ADDR_WIDTH+1 bits so it cannot wrap
- ACCESS:
  - mem_addr, mem_wd and mem_size come from the registers.
  - mem_we = we_q & ~err_q, decoded combinationally from the state. The write occurs at the end of this cycle.
  - Read data: on a read with no error, capture mem_rd into the winner's rdata at the end of the cycle. Writes and errored accesses load rdata = 0.
  - Next state = RESP.
- RESP:
  - The winner's ack is 1 for exactly this cycle; its err = err_q. The loser's ack and err stay 0.
  - rdata holds until that requester's next ack.
  - Next state = IDLE.
- Requester rule: req may drop or change command at the edge ending the RESP cycle. A req still high in IDLE is a new access.
- Fairness: a persistently requesting master waits at most one access of the other master.
- mem_addr, mem_wd and mem_size hold their last values outside ACCESS. mem_we is 0 outside ACCESS.
- A request dropped before ack is a protocol violation. The granted access still completes and still acks.
- Reset asserted mid-ACCESS: mem_we falls immediately and no write occurs at that edge. No ack is issued for the aborted access.

Test Plan:
- Reset, then m0 writes addr 0x10, size 10, wdata 0xDEADBEEF; then m0 reads 0x10 size 10 -> m0_ack two cycles after IDLE grant, err = 0; mem_we high only in ACCESS; read rdata = 0xDEADBEEF; busy pattern 1,1 then 0.
- m1 writes byte 0xAA at 0x13 size 00 over word 0x11223344 at 0x10; then reads 0x10 size 10 -> m1_rdata = 0xAA223344.
- m0_req and m1_req held high continuously -> grant order m0, m1, m0, m1, with acks alternating every 3 cycles.
- Illegal accesses:
  - m0 write size 10 at 0x02 -> err = 1, mem_we never high, memory unchanged.
  - size 11 -> err = 1.
  - addr 0x3FE size 10 with DEPTH 1024 -> err = 1.
  - addr 0xFFFFFFFF size 01 -> err = 1, no wrap.
- Reset asserted in the ACCESS cycle of a write to 0x20 -> mem_we drops asynchronously, memory unchanged, no ack; after release, the first tie goes to m0.
- m0 read of 0x3FC size 10 (last legal word) -> err = 0, correct data returned.
